// File: rtl/seq_cmp_n_if.sv
`default_nettype none
// ============================================================================
//  Module      : seq_cmp_n_if
//  Description : Request/result bundle for the sequential magnitude comparator.
//                The master drives operands and the start strobe; the slave
//                returns busy, the done pulse and the one-hot result flags.
//  Revision    : 1.0 - initial release
// ============================================================================
interface seq_cmp_n_if #(
    parameter int W = 8
);
    logic         start;
    logic         sgn;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         busy;
    logic         done;
    logic         eq;
    logic         lt;
    logic         gt;

    modport master (
        output start, sgn, x, y,
        input  busy, done, eq, lt, gt
    );

    modport slave (
        input  start, sgn, x, y,
        output busy, done, eq, lt, gt
    );
endinterface
`default_nettype wire

// File: rtl/seq_cmp_n.sv
`default_nettype none
// ============================================================================
//  Module      : seq_cmp_n
//  Description : Multi-cycle W-bit magnitude comparator, CHUNK bits per cycle,
//                MSB first, with early exit on the first differing chunk.
//                Signed operands are mapped to offset binary on capture so the
//                compare loop itself is always unsigned.
//                W must be a multiple of CHUNK.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_cmp_n #(
    parameter int W     = 8,
    parameter int CHUNK = 2
) (
    input  wire logic   clk,
    input  wire logic   rst_b,
    seq_cmp_n_if.slave  bus
);

    localparam int N       = W / CHUNK;
    localparam int c_CNT_W = $clog2(N + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(N);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [W-1:0]       r_xs;
    logic [W-1:0]       r_ys;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_done;
    logic               r_eq;
    logic               r_lt;
    logic               r_gt;

    logic [W-1:0]       w_xs_next;
    logic [W-1:0]       w_ys_next;
    logic [c_CNT_W-1:0] w_cnt_next;
    logic               w_done_next;
    logic               w_eq_next;
    logic               w_lt_next;
    logic               w_gt_next;

    logic [W-1:0]       w_sign_mask;
    logic [CHUNK-1:0]   w_xs_top;
    logic [CHUNK-1:0]   w_ys_top;
    logic [W-1:0]       w_xs_shift;
    logic [W-1:0]       w_ys_shift;

    // Flipping the MSB turns two's complement order into unsigned order.
    assign w_sign_mask = {bus.sgn, {(W-1){1'b0}}};
    assign w_xs_top    = r_xs[W-1 -: CHUNK];
    assign w_ys_top    = r_ys[W-1 -: CHUNK];

    // A single-chunk compare never shifts, so avoid a full-width shift there.
    generate
        if (N > 1) begin : g_shift
            assign w_xs_shift = r_xs << CHUNK;
            assign w_ys_shift = r_ys << CHUNK;
        end else begin : g_no_shift
            assign w_xs_shift = r_xs;
            assign w_ys_shift = r_ys;
        end
    endgenerate

    // State register.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    // Next state and next datapath values; flags hold unless a compare starts or ends.
    always_comb begin
        w_state_next = r_state;
        w_xs_next    = r_xs;
        w_ys_next    = r_ys;
        w_cnt_next   = r_cnt;
        w_done_next  = 1'b0;
        w_eq_next    = r_eq;
        w_lt_next    = r_lt;
        w_gt_next    = r_gt;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_next = S_RUN;
                    w_xs_next    = bus.x ^ w_sign_mask;
                    w_ys_next    = bus.y ^ w_sign_mask;
                    w_cnt_next   = c_CNT_LOAD;
                    w_eq_next    = 1'b0;
                    w_lt_next    = 1'b0;
                    w_gt_next    = 1'b0;
                end
            end
            S_RUN: begin
                if (w_xs_top != w_ys_top) begin
                    w_gt_next    = (w_xs_top > w_ys_top);
                    w_lt_next    = (w_xs_top < w_ys_top);
                    w_done_next  = 1'b1;
                    w_state_next = S_IDLE;
                end else if (r_cnt == c_CNT_ONE) begin
                    w_eq_next    = 1'b1;
                    w_done_next  = 1'b1;
                    w_state_next = S_IDLE;
                end else begin
                    w_xs_next  = w_xs_shift;
                    w_ys_next  = w_ys_shift;
                    w_cnt_next = r_cnt - c_CNT_ONE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Datapath and result registers; reset discards any in-flight compare.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_xs   <= '0;
            r_ys   <= '0;
            r_cnt  <= '0;
            r_done <= 1'b0;
            r_eq   <= 1'b0;
            r_lt   <= 1'b0;
            r_gt   <= 1'b0;
        end else begin
            r_xs   <= w_xs_next;
            r_ys   <= w_ys_next;
            r_cnt  <= w_cnt_next;
            r_done <= w_done_next;
            r_eq   <= w_eq_next;
            r_lt   <= w_lt_next;
            r_gt   <= w_gt_next;
        end
    end

    assign bus.busy = (r_state == S_RUN);
    assign bus.done = r_done;
    assign bus.eq   = r_eq;
    assign bus.lt   = r_lt;
    assign bus.gt   = r_gt;

endmodule
`default_nettype wire
